debouncer_multi: RTL and testbench

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

---
 rtl/debouncer_multi.sv | 86 ++++++++
 tb/tb_debouncer_multi.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel switch debouncer with a shared tick prescaler
// Each channel: 2-flop synchroniser, candidate level plus a saturating stability counter.
module debouncer_multi #(
  parameter int CHANNELS  = 4,
  parameter int DELAY     = 270000,
  parameter int TICK_DIV  = 1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int CW = $clog2(DELAY + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_VAL}};

  logic [PW-1:0]                  pre;
  logic                           tick;
  logic [CHANNELS-1:0]            s1;
  logic [CHANNELS-1:0]            s2;
  logic [CHANNELS-1:0]            cand;
  logic [CHANNELS-1:0]            cand_nx;
  logic [CHANNELS-1:0]            clean_nx;
  logic [CHANNELS-1:0][CW-1:0]    count;
  logic [CHANNELS-1:0][CW-1:0]    count_nx;

  // Free-running prescaler; input activity never resets it.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A level change restarts the count; the count saturates at DELAY and then keeps reloading clean.
  always_comb begin
    cand_nx  = cand;
    clean_nx = clean;
    count_nx = count;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s2[i] != cand[i]) begin
        cand_nx[i]  = s2[i];
        count_nx[i] = '0;
      end else if (count[i] == DELAY_C) begin
        clean_nx[i] = cand[i];
      end else if (tick) begin
        count_nx[i] = count[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= RST_VEC;
      s2      <= RST_VEC;
      cand    <= RST_VEC;
      clean   <= RST_VEC;
      count   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      s1      <= noisy;
      s2      <= s1;
      cand    <= cand_nx;
      count   <= count_nx;
      clean   <= clean_nx;
      rise    <= clean_nx & ~clean;
      fall    <= ~clean_nx & clean;
      changed <= |(clean_nx ^ clean);
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - self-checking bench for debouncer_multi
module tb_debouncer_multi;

  typedef struct {
    logic [3:0] noisy;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisy, noisy3;
  logic [3:0] clean, rise, fall;
  logic [3:0] clean3, rise3, fall3;
  logic       changed, changed3;
  int         passed = 0;
  int         total = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(4), .DELAY(4), .TICK_DIV(1), .RESET_VAL(1'b0)) dut (
    .clk(clk), .reset(reset), .noisy(noisy),
    .clean(clean), .rise(rise), .fall(fall), .changed(changed)
  );

  debouncer_multi #(.CHANNELS(4), .DELAY(4), .TICK_DIV(3), .RESET_VAL(1'b0)) dut3 (
    .clk(clk), .reset(reset), .noisy(noisy3),
    .clean(clean3), .rise(rise3), .fall(fall3), .changed(changed3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] n, input logic [3:0] c, input logic [3:0] r,
                     input logic [3:0] f, input logic ch);
    vec_t v;
    v.noisy = n; v.clean = c; v.rise = r; v.fall = f; v.changed = ch;
    vecs.push_back(v);
  endtask

  // Stable step from one settled level to another: 7 quiet edges, then the pulse edge.
  task automatic seg(input logic [3:0] from, input logic [3:0] to, input int hold);
    for (int i = 0; i < 7; i++) add(to, from, 4'b0000, 4'b0000, 1'b0);
    add(to, to, to & ~from, from & ~to, 1'b1);
    for (int i = 0; i < hold; i++) add(to, to, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int bad, first, nr, nf, nch;
    reset  = 1'b0;
    noisy  = 4'b0000;
    noisy3 = 4'b0000;

    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    seg(4'b0000, 4'b0001, 2);
    for (int i = 0; i < 3; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    seg(4'b0001, 4'b0011, 2);
    seg(4'b0011, 4'b1100, 2);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({clean, rise, fall, changed}), 32'h0);
    check("reset_state3", 32'({clean3, rise3, fall3, changed3}), 32'h0);
    #3 reset = 1'b1;

    for (int j = 0; j < vecs.size(); j++) begin
      noisy = vecs[j].noisy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", j), 32'({clean, rise, fall, changed}),
            32'({vecs[j].clean, vecs[j].rise, vecs[j].fall, vecs[j].changed}));
    end

    // Asynchronous reset mid-count
    noisy = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_clean", 32'(clean), 32'h1);
    noisy = 4'b0011;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset_clear", 32'({clean, rise, fall, changed}), 32'h0);
    noisy = 4'b0000;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    bad = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if ({clean, rise, fall, changed} != 13'h0) bad++;
    end
    check("post_reset_quiet", 32'(bad), 32'h0);

    noisy = 4'b0010;
    first = -1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      #1;
      if (clean[1] && first < 0) first = e;
    end
    check("restart_latency", 32'(first), 32'd7);

    // Chatter on channel 2, then settle high
    nr = 0; nf = 0; nch = 0; first = -1;
    for (int e = 0; e < 40; e++) begin
      noisy[2] = (e < 20) ? ((e / 2) % 2 == 0) : 1'b1;
      @(posedge clk);
      #1;
      if (rise[2]) begin
        nr++;
        if (first < 0) first = e;
      end
      if (fall[2]) nf++;
      if (changed) nch++;
    end
    check("chatter_rise_count", 32'(nr), 32'd1);
    check("chatter_rise_edge", 32'(first), 32'd27);
    check("chatter_fall_count", 32'(nf), 32'd0);
    check("chatter_changed_count", 32'(nch), 32'd1);
    check("chatter_clean", 32'(clean), 32'h6);

    // Prescaler TICK_DIV=3
    check("pre3_idle", 32'({clean3, rise3, fall3, changed3}), 32'h0);
    noisy3 = 4'b0001;
    nr = 0; first = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (rise3[0]) nr++;
      if (clean3[0] && first < 0) first = e;
    end
    check("pre3_window", 32'(first >= 13 && first <= 17), 32'd1);
    check("pre3_rise_count", 32'(nr), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
